// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
//   Types shared by the instruction fetch stage and its response FIFO.
//   - instruction_s : one instruction word as stored in instr_mem
//   - fetch_state_e : fetch controller states
//   - FIFO_DEPTH    : number of fetched instructions that can be buffered
package fetch_unit_pkg;

  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_s;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo
//   Two-entry FIFO of {instruction, pc} between the instruction memory
//   response and decode. The head is read straight out of the storage
//   registers, so the outputs are registered and hold still while nothing
//   is dequeued.
// Ports
//   clk           clock
//   reset_n_i     synchronous active-low reset (empties, zeroes storage)
//   enq_i         push {enq_instr_i, enq_pc_i}
//   deq_i         pop head (ignored when empty)
//   flush_i       discard all entries; wins over enq/deq
//   v_o           head entry valid
//   head_instr_o  head instruction
//   head_pc_o     head pc
//   count_o       occupancy, 0..2
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    enq_i,
  input  instruction_s            enq_instr_i,
  input  logic [addr_width_p-1:0] enq_pc_i,
  input  logic                    deq_i,
  input  logic                    flush_i,
  output logic                    v_o,
  output instruction_s            head_instr_o,
  output logic [addr_width_p-1:0] head_pc_o,
  output logic [1:0]              count_o
);

  instruction_s            instr_q [FIFO_DEPTH];
  instruction_s            instr_d [FIFO_DEPTH];
  logic [addr_width_p-1:0] pc_q    [FIFO_DEPTH];
  logic [addr_width_p-1:0] pc_d    [FIFO_DEPTH];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    deq_ok;

  assign deq_ok = deq_i && (count_q != 2'd0);

  always_comb begin
    instr_d  = instr_q;
    pc_d     = pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (enq_i) begin
        instr_d[wr_ptr_q] = enq_instr_i;
        pc_d[wr_ptr_q]    = enq_pc_i;
        wr_ptr_d          = ~wr_ptr_q;
      end
      if (deq_ok) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({enq_i, deq_ok})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign v_o          = (count_q != 2'd0);
  assign head_instr_o = instr_q[rd_ptr_q];
  assign head_pc_o    = pc_q[rd_ptr_q];
  assign count_o      = count_q;

  // The issue rule upstream keeps reads in flight plus buffered entries
  // within capacity, so a push into a full FIFO means that rule broke.
  enq_not_full_a: assert property (
    @(posedge clk) disable iff (!reset_n_i)
    !(enq_i && !flush_i && (count_q == 2'd2))
  );

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage in front of the synchronous instr_mem. Owns the
//   pc, drives the memory port (program load writes or fetch reads), hides
//   the one-cycle read latency and presents {instruction, pc} to decode
//   through a valid/ready handshake.
// Ports
//   clk             clock
//   reset_n_i       synchronous active-low reset
//   start_i         IDLE: start fetching at pc 0
//   load_en_i       program-load mode request (beats start and redirect)
//   load_addr_i     load write address
//   load_instr_i    load write data
//   redirect_v_i    RUN: redirect strobe
//   redirect_pc_i   redirect target
//   imem_addr_o     memory address        (combinational)
//   imem_wen_o      memory write enable   (combinational)
//   imem_instr_o    memory write data     (combinational)
//   imem_instr_i    memory read data, one cycle after the address
//   instr_v_o       instruction valid to decode
//   instr_o         instruction to decode
//   instr_pc_o      pc of instr_o
//   instr_ready_i   decode accepts when high together with instr_v_o
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    start_i,
  input  logic                    load_en_i,
  input  logic [addr_width_p-1:0] load_addr_i,
  input  instruction_s            load_instr_i,
  input  logic                    redirect_v_i,
  input  logic [addr_width_p-1:0] redirect_pc_i,
  output logic [addr_width_p-1:0] imem_addr_o,
  output logic                    imem_wen_o,
  output instruction_s            imem_instr_o,
  input  instruction_s            imem_instr_i,
  output logic                    instr_v_o,
  output instruction_s            instr_o,
  output logic [addr_width_p-1:0] instr_pc_o,
  input  logic                    instr_ready_i
);

  fetch_state_e            state_q, state_d;
  logic [addr_width_p-1:0] pc_q, pc_d;
  logic                    inflight_q, inflight_d;
  logic [addr_width_p-1:0] inflight_pc_q, inflight_pc_d;

  logic       fifo_v;
  logic [1:0] fifo_count;
  logic       flush;
  logic       enq;
  logic       deq;
  logic [2:0] demand;
  logic       issue_ok;

  // A redirect or load request in RUN throws away everything buffered; the
  // head is hidden in that same cycle so decode cannot take a stale entry.
  assign flush     = (state_q == RUN) && (load_en_i || redirect_v_i);
  assign instr_v_o = fifo_v && !flush;
  assign deq       = instr_v_o && instr_ready_i;

  // Buffered + in flight - leaving this cycle must stay under capacity
  // after the new read lands.
  assign demand   = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign issue_ok = demand < (3'd2 + {2'b00, deq});

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    imem_addr_o   = pc_q;
    imem_wen_o    = 1'b0;
    imem_instr_o  = '0;
    enq           = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en_i) begin
          state_d = LOAD;
        end else if (start_i) begin
          state_d = RUN;
          pc_d    = '0;
        end
      end
      LOAD: begin
        if (load_en_i) begin
          imem_addr_o  = load_addr_i;
          imem_wen_o   = 1'b1;
          imem_instr_o = load_instr_i;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (load_en_i) begin
          state_d    = LOAD;
          inflight_d = 1'b0;
        end else if (redirect_v_i) begin
          // Target read goes out now; the pending response is dropped.
          imem_addr_o   = redirect_pc_i;
          inflight_d    = 1'b1;
          inflight_pc_d = redirect_pc_i;
          pc_d          = redirect_pc_i + 1'b1;
        end else begin
          enq = inflight_q;
          if (issue_ok) begin
            inflight_d    = 1'b1;
            inflight_pc_d = pc_q;
            pc_d          = pc_q + 1'b1;
          end else begin
            inflight_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_fifo #(
    .addr_width_p(addr_width_p)
  ) u_fifo (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .enq_i        (enq),
    .enq_instr_i  (imem_instr_i),
    .enq_pc_i     (inflight_pc_q),
    .deq_i        (deq),
    .flush_i      (flush),
    .v_o          (fifo_v),
    .head_instr_o (instr_o),
    .head_pc_o    (instr_pc_o),
    .count_o      (fifo_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          reset_n_i;
  logic          start_i;
  logic          load_en_i;
  logic [AW-1:0] load_addr_i;
  instruction_s  load_instr_i;
  logic          redirect_v_i;
  logic [AW-1:0] redirect_pc_i;
  logic [AW-1:0] imem_addr_o;
  logic          imem_wen_o;
  instruction_s  imem_instr_o;
  instruction_s  imem_instr_i;
  logic          instr_v_o;
  instruction_s  instr_o;
  logic [AW-1:0] instr_pc_o;
  logic          instr_ready_i;

  always #5 clk = ~clk;

  fetch_unit #(.addr_width_p(AW)) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .start_i       (start_i),
    .load_en_i     (load_en_i),
    .load_addr_i   (load_addr_i),
    .load_instr_i  (load_instr_i),
    .redirect_v_i  (redirect_v_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_addr_o   (imem_addr_o),
    .imem_wen_o    (imem_wen_o),
    .imem_instr_o  (imem_instr_o),
    .imem_instr_i  (imem_instr_i),
    .instr_v_o     (instr_v_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i)
  );

  // Synchronous instruction memory model: one-cycle read latency.
  instruction_s mem [1024];
  always @(posedge clk) begin
    if (imem_wen_o) mem[imem_addr_o] <= imem_instr_o;
    imem_instr_i <= mem[imem_addr_o];
  end

  // Bench-side record of what was loaded, used for expected data.
  logic [31:0] expmem [1024];

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          ready;
    logic          exp_v;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] exp_addr;
  } vec_t;

  vec_t vecs [12];

  logic [AW-1:0] lq [$];
  logic [31:0]   dq [$];

  // Enters LOAD from IDLE and writes every queued word, one per cycle.
  task automatic do_load(input logic with_start);
    load_en_i = 1'b1;
    start_i   = with_start;
    #1;
    check("idle_no_write", imem_wen_o, 0);
    tick();
    start_i = 1'b0;
    foreach (lq[i]) begin
      load_addr_i  = lq[i];
      load_instr_i = instruction_s'(dq[i]);
      #1;
      check("load_wen", imem_wen_o, 1);
      check("load_addr", imem_addr_o, lq[i]);
      check("load_data", imem_instr_o, dq[i]);
      expmem[lq[i]] = dq[i];
      tick();
    end
    load_en_i = 1'b0;
    #1;
    check("load_exit_wen", imem_wen_o, 0);
    tick();
  endtask

  task automatic check_out(input string name, input logic exp_v, input logic [AW-1:0] exp_pc);
    check({name, "_v"}, instr_v_o, exp_v);
    if (exp_v) begin
      check({name, "_pc"}, instr_pc_o, exp_pc);
      check({name, "_instr"}, instr_o, expmem[exp_pc]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) expmem[i] = 32'h0;

    // Cycle table from the first RUN cycle: 5 cycles of backpressure start
    // at the second valid; pc 1 must stay put until ready returns.
    vecs[0]  = '{1'b1, 1'b0, 10'd0, 10'd0};
    vecs[1]  = '{1'b1, 1'b0, 10'd0, 10'd1};
    vecs[2]  = '{1'b1, 1'b1, 10'd0, 10'd2};
    vecs[3]  = '{1'b0, 1'b1, 10'd1, 10'd3};
    vecs[4]  = '{1'b0, 1'b1, 10'd1, 10'd3};
    vecs[5]  = '{1'b0, 1'b1, 10'd1, 10'd3};
    vecs[6]  = '{1'b0, 1'b1, 10'd1, 10'd3};
    vecs[7]  = '{1'b0, 1'b1, 10'd1, 10'd3};
    vecs[8]  = '{1'b1, 1'b1, 10'd1, 10'd3};
    vecs[9]  = '{1'b1, 1'b1, 10'd2, 10'd4};
    vecs[10] = '{1'b1, 1'b1, 10'd3, 10'd5};
    vecs[11] = '{1'b1, 1'b1, 10'd4, 10'd6};

    for (int i = 0; i < 16; i++) begin
      lq.push_back(AW'(i));
      dq.push_back(32'hA + i);
    end
    for (int i = 0; i < 4; i++) begin
      lq.push_back(AW'(10'h100 + i));
      dq.push_back(32'h00AB_0100 + i);
    end
    lq.push_back(10'h3FE); dq.push_back(32'h00CD_03FE);
    lq.push_back(10'h3FF); dq.push_back(32'h00CD_03FF);

    reset_n_i     = 1'b0;
    start_i       = 1'b0;
    load_en_i     = 1'b0;
    load_addr_i   = '0;
    load_instr_i  = '0;
    redirect_v_i  = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    tick();
    tick();
    check("rst_v", instr_v_o, 0);
    check("rst_wen", imem_wen_o, 0);
    check("rst_addr", imem_addr_o, 0);
    check("rst_pc", instr_pc_o, 0);
    check("rst_instr", instr_o, 0);
    reset_n_i = 1'b1;

    // Redirect in IDLE does nothing.
    redirect_v_i  = 1'b1;
    redirect_pc_i = 10'h55;
    #1;
    check("idle_redir_addr", imem_addr_o, 0);
    tick();
    redirect_v_i = 1'b0;
    #1;
    check("idle_redir_v", instr_v_o, 0);
    check("idle_redir_addr2", imem_addr_o, 0);

    // load_en beats start in IDLE.
    do_load(1'b1);

    // Load then run, with backpressure.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      instr_ready_i = vecs[i].ready;
      #1;
      check_out($sformatf("run%0d", i), vecs[i].exp_v, vecs[i].exp_pc);
      check($sformatf("run%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
      check($sformatf("run%0d_wen", i), imem_wen_o, 0);
      tick();
    end

    // Redirect with two entries buffered (pc 5, 6).
    instr_ready_i = 1'b0;
    #1;
    check_out("pre_redir", 1'b1, 10'd5);
    tick();
    redirect_v_i  = 1'b1;
    redirect_pc_i = 10'h100;
    instr_ready_i = 1'b1;
    #1;
    check("redir_v", instr_v_o, 0);
    check("redir_addr", imem_addr_o, 10'h100);
    tick();
    redirect_v_i = 1'b0;
    #1;
    check("redir_p1_v", instr_v_o, 0);
    check("redir_p1_addr", imem_addr_o, 10'h101);
    tick();
    check_out("redir_first", 1'b1, 10'h100);
    tick();
    check_out("redir_second", 1'b1, 10'h101);
    tick();

    // Wrap around the top of the address space.
    redirect_v_i  = 1'b1;
    redirect_pc_i = 10'h3FE;
    #1;
    check("wrap_redir_v", instr_v_o, 0);
    tick();
    redirect_v_i = 1'b0;
    #1;
    check("wrap_p1_v", instr_v_o, 0);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_out($sformatf("wrap%0d", k), 1'b1, AW'((1022 + k) % 1024));
      tick();
    end

    // Fill the FIFO, then reset for one cycle.
    instr_ready_i = 1'b0;
    tick();
    #1;
    check("full_v", instr_v_o, 1);
    tick();
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    #1;
    check("mrst_v", instr_v_o, 0);
    check("mrst_addr", imem_addr_o, 0);
    check("mrst_pc", instr_pc_o, 0);
    check("mrst_instr", instr_o, 0);
    check("mrst_wen", imem_wen_o, 0);
    tick();
    check("mrst_idle_v", instr_v_o, 0);

    // Restart: memory still holds the program.
    start_i = 1'b1;
    tick();
    start_i       = 1'b0;
    instr_ready_i = 1'b1;
    #1;
    check("rs0_v", instr_v_o, 0);
    tick();
    check("rs1_v", instr_v_o, 0);
    tick();
    check_out("rs2", 1'b1, 10'd0);
    tick();
    check_out("rs3", 1'b1, 10'd1);
    tick();

    // load_en in RUN: flush, no delivery, write from the next cycle.
    load_en_i = 1'b1;
    #1;
    check("runload_v", instr_v_o, 0);
    check("runload_wen", imem_wen_o, 0);
    tick();
    load_addr_i  = 10'h20;
    load_instr_i = instruction_s'(32'h0000_0077);
    #1;
    check("runload_w_wen", imem_wen_o, 1);
    check("runload_w_addr", imem_addr_o, 10'h20);
    check("runload_w_v", instr_v_o, 0);
    expmem[10'h20] = 32'h0000_0077;
    tick();
    load_en_i = 1'b0;
    #1;
    check("runload_exit_wen", imem_wen_o, 0);
    check("runload_exit_v", instr_v_o, 0);
    tick();
    check("runload_idle_v", instr_v_o, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
